// File: rtl/uart_recv.sv
// UART receiver, 8N1, LSB first: start-edge detect, mid-bit sampling, 1-cycle valid / frame_err pulses.
// Optional 2-flop input synchronizer on din, enabled by defining UART_RECV_SYNC_EN.
module uart_recv #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 9600,
   parameter int DIVIDER    = CLOCK_FREQ / BAUD_RATE - 1,
   parameter int HALF       = (DIVIDER + 1) / 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam logic [13:0] L_DIV  = 14'(DIVIDER);
   localparam logic [13:0] L_HALF = 14'(HALF);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [13:0] r_cnt;
   logic [2:0]  r_bit_idx;
   logic [7:0]  r_shreg;
   logic        r_din_prev;
   logic [7:0]  r_data;
   logic        r_valid;
   logic        r_frame_err;
   logic        w_din;
   logic        w_fall;
   logic        w_half_hit;
   logic        w_bit_hit;
   logic        w_shift;
   logic        w_good;
   logic        w_bad;
   logic        w_cnt_clr;

`ifdef UART_RECV_SYNC_EN
   logic [1:0] r_sync;

   // Two-flop synchronizer; resets to the idle-high line level so reset release never looks like a start edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 2'b11;
      end else begin
         r_sync <= {r_sync[0], din};
      end
   end

   assign w_din = r_sync[1];
`else
   assign w_din = din;
`endif

   assign w_fall = ~w_din & r_din_prev;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_fall) w_next = S_START;
            else        w_next = S_IDLE;
         end
         S_START: begin
            if (w_half_hit) w_next = w_din ? S_IDLE : S_DATA;
            else            w_next = S_START;
         end
         S_DATA: begin
            if (w_bit_hit && (r_bit_idx == 3'd7)) w_next = S_STOP;
            else                                  w_next = S_DATA;
         end
         S_STOP: begin
            if (w_bit_hit) w_next = S_IDLE;
            else           w_next = S_STOP;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_half_hit = (r_cnt == L_HALF);
      w_bit_hit  = (r_cnt == L_DIV);
      w_shift    = (r_state == S_DATA) && w_bit_hit;
      w_good     = (r_state == S_STOP) && w_bit_hit && w_din;
      w_bad      = (r_state == S_STOP) && w_bit_hit && ~w_din;
      // DATA stays in-state across bits, so its terminal count must also wrap the counter
      w_cnt_clr  = (r_state == S_IDLE) || (w_next != r_state) || w_shift;
      busy       = (r_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 14'd0;
         r_bit_idx   <= 3'd0;
         r_shreg     <= 8'd0;
         r_din_prev  <= 1'b1;
         r_data      <= 8'd0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_din_prev <= w_din;
         if (w_cnt_clr) r_cnt <= 14'd0;
         else           r_cnt <= r_cnt + 14'd1;
         if (w_shift) begin
            r_shreg[r_bit_idx] <= w_din;
            r_bit_idx          <= r_bit_idx + 3'd1;
         end else if (r_state == S_IDLE) begin
            r_bit_idx <= 3'd0;
         end else begin
            r_bit_idx <= r_bit_idx;
         end
         if (w_good) r_data <= r_shreg;
         else        r_data <= r_data;
         r_valid     <= w_good;
         r_frame_err <= w_bad;
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_recv.sv
// Self-checking bench for uart_recv: a behavioural 8N1 sender drives din, a scoreboard queue holds expected
// frames and a negedge monitor pops/compares them. Uses a scaled divider (16 clocks per bit).
module tb_uart_recv;

   localparam int DIV  = 15;
   localparam int HALF = 8;
   localparam int BIT  = DIV + 1;
`ifdef UART_RECV_SYNC_EN
   localparam int LAT  = HALF + 9 * BIT + 2 + 2;
`else
   localparam int LAT  = HALF + 9 * BIT + 2;
`endif

   typedef struct packed {
      logic       is_err;
      logic [7:0] d;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b1;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         fall_cyc = 0;
   int         last_valid_cyc = 0;
   int         n_valid = 0;
   int         n_ferr = 0;
   logic [7:0] exp_last = 8'h00;
   logic       prev_out = 1'b0;

   uart_recv #(.CLOCK_FREQ(160), .BAUD_RATE(10)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .data      (data),
      .valid     (valid),
      .frame_err (frame_err),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard monitor: every output pulse must match the oldest expected frame
   always @(negedge clk) begin
      exp_t e;
      if (!rst && (valid || frame_err)) begin
         chk("exclusive", {31'd0, valid & frame_err}, 32'd0);
         chk("pulse_width", {31'd0, prev_out}, 32'd0);
         if (q.size() == 0) begin
            chk("unexpected_out", {30'd0, frame_err, valid}, 32'd0);
         end else begin
            e = q.pop_front();
            chk("out_kind", {31'd0, frame_err}, {31'd0, e.is_err});
            chk("out_data", {24'd0, data}, {24'd0, e.d});
         end
         if (valid) begin
            n_valid++;
            last_valid_cyc = cyc;
         end
         if (frame_err) n_ferr++;
      end
      prev_out = valid | frame_err;
   end

   task automatic drive_bit(input logic v);
      din = v;
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      if (stop) begin
         q.push_back('{is_err: 1'b0, d: b});
         exp_last = b;
      end else begin
         q.push_back('{is_err: 1'b1, d: exp_last});
      end
      fall_cyc = cyc;
      drive_bit(1'b0);
      chk("busy_mid", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 4 * BIT && q.size() != 0; k++) @(posedge clk);
      #1;
      chk(tag, q.size(), 32'd0);
   endtask

   initial begin
      logic [7:0] c3;
      int         nv0;
      int         nf0;
      c3 = 8'hC3;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {24'd0, data}, 32'd0);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_ferr", {31'd0, frame_err}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;

      // Test 1: single frame, latency
      send_frame(8'hA5, 1'b1);
      drain("t1_drain");
      chk("t1_nvalid", n_valid, 32'd1);
      chk("t1_nferr", n_ferr, 32'd0);
      chk("t1_latency", last_valid_cyc - fall_cyc, LAT);
      chk("t1_data", {24'd0, data}, 32'hA5);
      chk("t1_idle", {31'd0, busy}, 32'd0);
      repeat (BIT) @(posedge clk);
      #1;

      // Test 2: back-to-back frames
      send_frame(8'h3C, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h00, 1'b1);
      send_frame(8'h5A, 1'b1);
      drain("t2_drain");
      chk("t2_nvalid", n_valid, 32'd5);
      chk("t2_data", {24'd0, data}, 32'h5A);
      repeat (BIT) @(posedge clk);
      #1;

      // Test 3: short low glitch shorter than half a bit
      nv0 = n_valid;
      nf0 = n_ferr;
      din = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("t3_busy_start", {31'd0, busy}, 32'd1);
      din = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("t3_busy_idle", {31'd0, busy}, 32'd0);
      repeat (12 * BIT) @(posedge clk);
      #1;
      chk("t3_novalid", n_valid, nv0);
      chk("t3_noferr", n_ferr, nf0);

      // Test 4: bad stop bit, line then held low (break) -> exactly one frame_err
      send_frame(8'h81, 1'b0);
      repeat (3 * BIT) @(posedge clk);
      #1;
      din = 1'b1;
      drain("t4_drain");
      repeat (2 * BIT) @(posedge clk);
      #1;
      chk("t4_nferr", n_ferr, nf0 + 1);
      chk("t4_nvalid", n_valid, nv0);
      chk("t4_data_held", {24'd0, data}, 32'h5A);
      chk("t4_idle", {31'd0, busy}, 32'd0);

      // Test 5: reset during bit 4 of 8'hC3, then a clean 8'h96
      nv0 = n_valid;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(c3[i]);
      din = c3[4];
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_last = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      din = 1'b1;
      chk("t5_data", {24'd0, data}, 32'd0);
      chk("t5_valid", {31'd0, valid}, 32'd0);
      chk("t5_ferr", {31'd0, frame_err}, 32'd0);
      chk("t5_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      repeat (2 * BIT) @(posedge clk);
      #1;
      chk("t5_novalid", n_valid, nv0);
      send_frame(8'h96, 1'b1);
      drain("t5_drain");
      chk("t5_nvalid", n_valid, nv0 + 1);
      chk("t5_data_next", {24'd0, data}, 32'h96);
      chk("t5_latency", last_valid_cyc - fall_cyc, LAT);

      repeat (BIT) @(posedge clk);
      chk("final_queue", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
